// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared constants and state encoding for the USB IN packet controller
//
// Purpose : parameter defaults, count-width constants and the controller
//           state type used by usb_tx_pkt_ctrl and usb_tx_flush_timer.
// Ports   : none (package).
package usb_tx_pkg;

  localparam int MAX_PKT_DEF   = 512;   // largest IN payload in bytes
  localparam int FLUSH_CYC_DEF = 4096;  // idle cycles before a short packet may go out
  localparam int ASIZE_DEF     = 9;     // packet-FIFO address width
  localparam int CNT_W_DEF     = ASIZE_DEF + 1;  // byte-count width

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    SEND     = 3'd2,
    WAIT_ACK = 3'd3,
    COMMIT   = 3'd4,
    REWIND   = 3'd5
  } tx_state_e;

endpackage

// File: rtl/usb_tx_flush_timer.sv
// rtl/usb_tx_flush_timer.sv - saturating idle timer that releases short packets
//
// Purpose : counts cycles while run is high, saturates at FLUSH_CYC and
//           reports expired once saturated. clr (or RST) returns it to 0.
// Ports   : CLK     in  clock, rising edge
//           RST     in  synchronous active-high reset
//           run     in  count enable
//           clr     in  synchronous clear, wins over run
//           expired out count has reached FLUSH_CYC
module usb_tx_flush_timer
  import usb_tx_pkg::*;
#(
  parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int            TW    = $clog2(FLUSH_CYC + 1);
  localparam logic [TW-1:0] LIMIT = TW'(FLUSH_CYC);

  logic [TW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (run && (cnt != LIMIT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/usb_tx_pkt_ctrl.sv
// rtl/usb_tx_pkt_ctrl.sv - IN-endpoint packet controller between packet FIFO and USB engine
//
// Purpose : decides on each IN token whether to send a packet or NAK,
//           streams the packet out of the FIFO, and on ACK commits it or on
//           retry rewinds the FIFO and resends the same bytes.
// Ports   : CLK          in  clock, rising edge
//           RST          in  synchronous active-high reset
//           fifo_wrnum   in  bytes buffered beyond the last committed packet
//           in_req       in  IN token pulse
//           tx_pop       in  USB engine takes the current byte
//           usb_ack      in  host ACK pulse
//           usb_retry    in  resend request pulse
//           fifo_read    out FIFO read strobe
//           fifo_txact   out packet-active level; its rising edge rewinds the FIFO
//           fifo_pktfin  out one-cycle commit pulse
//           tx_vld       out current byte valid
//           tx_last      out current byte is the final one
//           tx_nak       out one-cycle NAK response
//           tx_len       out length of the packet in flight
module usb_tx_pkt_ctrl
  import usb_tx_pkg::*;
#(
  parameter int MAX_PKT   = MAX_PKT_DEF,
  parameter int FLUSH_CYC = FLUSH_CYC_DEF,
  parameter int ASIZE     = ASIZE_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [ASIZE:0]   fifo_wrnum,
  input  logic             in_req,
  input  logic             tx_pop,
  input  logic             usb_ack,
  input  logic             usb_retry,
  output logic             fifo_read,
  output logic             fifo_txact,
  output logic             fifo_pktfin,
  output logic             tx_vld,
  output logic             tx_last,
  output logic             tx_nak,
  output logic [ASIZE:0]   tx_len
);

  localparam int            CW    = ASIZE + 1;
  localparam logic [CW-1:0] MAX_W = CW'(MAX_PKT);
  localparam logic [CW-1:0] ONE_W = CW'(1);

  tx_state_e     state, state_nx;
  logic          arm_cnt, arm_cnt_nx;
  logic [CW-1:0] rem, rem_nx;
  logic [CW-1:0] len_nx;
  logic          nak_nx;

  logic          have_data;
  logic          full_pkt;
  logic          timer_run;
  logic          timer_clr;
  logic          flush_expired;

  assign have_data = (fifo_wrnum != '0);
  assign full_pkt  = (fifo_wrnum >= MAX_W);

  // The timer only ages a partial packet while we sit idle; an empty FIFO
  // or a committed packet starts the wait over.
  assign timer_run = (state == IDLE) && have_data && !full_pkt;
  assign timer_clr = !have_data || (state == COMMIT);

  usb_tx_flush_timer #(
    .FLUSH_CYC (FLUSH_CYC)
  ) u_flush_timer (
    .CLK     (CLK),
    .RST     (RST),
    .run     (timer_run),
    .clr     (timer_clr),
    .expired (flush_expired)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      arm_cnt <= 1'b0;
      rem     <= '0;
      tx_len  <= '0;
      tx_nak  <= 1'b0;
    end else begin
      state   <= state_nx;
      arm_cnt <= arm_cnt_nx;
      rem     <= rem_nx;
      tx_len  <= len_nx;
      tx_nak  <= nak_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    arm_cnt_nx  = 1'b0;
    rem_nx      = rem;
    len_nx      = tx_len;
    nak_nx      = 1'b0;
    fifo_txact  = 1'b0;
    fifo_read   = 1'b0;
    fifo_pktfin = 1'b0;
    tx_vld      = 1'b0;
    tx_last     = 1'b0;

    case (state)
      IDLE: begin
        if (in_req) begin
          if (full_pkt || (have_data && flush_expired)) begin
            len_nx   = full_pkt ? MAX_W : fifo_wrnum;
            state_nx = ARM;
          end else begin
            nak_nx = 1'b1;
          end
        end
      end

      // Two quiet cycles give the FIFO's txact edge detector time to
      // rewind its read pointer before the first byte is requested.
      ARM: begin
        fifo_txact = 1'b1;
        if (arm_cnt) begin
          rem_nx   = tx_len;
          state_nx = SEND;
        end else begin
          arm_cnt_nx = 1'b1;
        end
      end

      SEND: begin
        fifo_txact = 1'b1;
        tx_vld     = 1'b1;
        tx_last    = (rem == ONE_W);
        fifo_read  = tx_pop;
        if (usb_retry) begin
          state_nx = REWIND;
        end else if (tx_pop) begin
          rem_nx = rem - ONE_W;
          if (rem == ONE_W) begin
            state_nx = WAIT_ACK;
          end
        end
      end

      WAIT_ACK: begin
        fifo_txact = 1'b1;
        if (usb_ack) begin
          state_nx = COMMIT;
        end else if (usb_retry) begin
          state_nx = REWIND;
        end
      end

      COMMIT: begin
        fifo_pktfin = 1'b1;
        state_nx    = IDLE;
      end

      // One cycle with txact low so the next ARM produces a fresh rising edge.
      REWIND: begin
        state_nx = ARM;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_tx_pkt_ctrl.sv
// tb/tb_usb_tx_pkt_ctrl.sv - self-checking bench for usb_tx_pkt_ctrl
module tb_usb_tx_pkt_ctrl;

  localparam int MAX_PKT   = 512;
  localparam int FLUSH_CYC = 4096;
  localparam int ASIZE     = 9;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [ASIZE:0] fifo_wrnum = '0;
  logic           in_req = 1'b0;
  logic           tx_pop = 1'b0;
  logic           usb_ack = 1'b0;
  logic           usb_retry = 1'b0;
  logic           fifo_read, fifo_txact, fifo_pktfin;
  logic           tx_vld, tx_last, tx_nak;
  logic [ASIZE:0] tx_len;

  int checks = 0;
  int errors = 0;

  // Reference model: flush-timer age and where the packet protocol stands.
  int m_timer  = 0;
  bit m_idle   = 1'b1;
  bit m_commit = 1'b0;

  usb_tx_pkt_ctrl #(
    .MAX_PKT   (MAX_PKT),
    .FLUSH_CYC (FLUSH_CYC),
    .ASIZE     (ASIZE)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .fifo_wrnum  (fifo_wrnum),
    .in_req      (in_req),
    .tx_pop      (tx_pop),
    .usb_ack     (usb_ack),
    .usb_retry   (usb_retry),
    .fifo_read   (fifo_read),
    .fifo_txact  (fifo_txact),
    .fifo_pktfin (fifo_pktfin),
    .tx_vld      (tx_vld),
    .tx_last     (tx_last),
    .tx_nak      (tx_nak),
    .tx_len      (tx_len)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, first applying the timer rule to the edge about to happen.
  task automatic tick();
    if (RST) m_timer = 0;
    else if (fifo_wrnum == 0 || m_commit) m_timer = 0;
    else if (m_idle && fifo_wrnum < MAX_PKT && m_timer < FLUSH_CYC) m_timer++;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_until(input int target);
    int g;
    g = 0;
    while (m_timer < target && g < 2 * FLUSH_CYC) begin
      tick();
      g++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read"},   fifo_read,   0);
    chk({tag, "_txact"},  fifo_txact,  0);
    chk({tag, "_pktfin"}, fifo_pktfin, 0);
    chk({tag, "_vld"},    tx_vld,      0);
    chk({tag, "_last"},   tx_last,     0);
    chk({tag, "_nak"},    tx_nak,      0);
    chk({tag, "_len"},    tx_len,      0);
  endtask

  // mode: 0 plain ack, 1 retry in WAIT_ACK, 2 retry mid-SEND, 3 ack+retry together
  task automatic run_packet(input int wr, input int mode, input int abort_idx);
    int len, idx, guard, nreads, waits;
    bit accept, retried, done, restart, blown;
    fifo_wrnum = wr[ASIZE:0];
    accept = (wr >= MAX_PKT) || (wr > 0 && m_timer >= FLUSH_CYC);
    len    = (wr > MAX_PKT) ? MAX_PKT : wr;
    in_req = 1'b1;
    #1 chk("req_txact", fifo_txact, 0);
    tick();
    in_req = 1'b0;
    if (!accept) begin
      #1;
      chk("nak_pulse", tx_nak, 1);
      chk("nak_no_txact", fifo_txact, 0);
      tick();
      #1 chk("nak_single", tx_nak, 0);
      tick();
      return;
    end
    m_idle  = 1'b0;
    retried = 1'b0;
    done    = 1'b0;
    blown   = 1'b0;
    if (abort_idx < 0) abort_idx = $urandom_range(len - 1, 0);
    while (!done && !blown) begin
      for (int c = 0; c < 2; c++) begin
        tx_pop  = 1'($urandom_range(1, 0));
        usb_ack = 1'($urandom_range(1, 0));
        #1;
        chk("arm_txact", fifo_txact, 1);
        chk("arm_no_read", fifo_read, 0);
        chk("arm_no_vld", tx_vld, 0);
        chk("arm_len", tx_len, len);
        tick();
      end
      tx_pop  = 1'b0;
      usb_ack = 1'b0;
      idx = 0; guard = 0; nreads = 0; restart = 1'b0;
      while (idx < len && !restart && !blown) begin
        if (mode == 2 && !retried && idx == abort_idx) begin
          usb_retry = 1'b1;
          #1 chk("abort_vld", tx_vld, 1);
          tick();
          usb_retry = 1'b0;
          retried   = 1'b1;
          restart   = 1'b1;
        end else begin
          tx_pop  = ($urandom_range(3, 0) != 0);
          usb_ack = ($urandom_range(15, 0) == 0);
          in_req  = ($urandom_range(15, 0) == 0);
          #1;
          chk("send_vld", tx_vld, 1);
          chk("send_last", tx_last, (idx == len - 1));
          chk("send_read", fifo_read, tx_pop);
          tick();
          if (tx_pop) begin
            idx++;
            nreads++;
          end
          tx_pop = 1'b0; usb_ack = 1'b0; in_req = 1'b0;
          guard++;
          if (guard > 8 * MAX_PKT) begin
            chk("send_budget", guard, 0);
            blown = 1'b1;
          end
        end
      end
      if (blown) break;
      if (!restart) begin
        chk("attempt_reads", nreads, len);
        waits = $urandom_range(3, 0);
        for (int w = 0; w < waits; w++) begin
          in_req = 1'($urandom_range(1, 0));
          #1;
          chk("wait_txact", fifo_txact, 1);
          chk("wait_vld", tx_vld, 0);
          chk("wait_pktfin", fifo_pktfin, 0);
          tick();
          in_req = 1'b0;
        end
        if (mode == 1 && !retried) begin
          usb_retry = 1'b1;
          #1 chk("retry_txact", fifo_txact, 1);
          tick();
          usb_retry = 1'b0;
          retried   = 1'b1;
          restart   = 1'b1;
        end else begin
          usb_ack   = 1'b1;
          usb_retry = (mode == 3);
          #1 chk("ack_txact", fifo_txact, 1);
          tick();
          usb_ack = 1'b0; usb_retry = 1'b0;
          m_commit = 1'b1;
          #1;
          chk("commit_pktfin", fifo_pktfin, 1);
          chk("commit_txact", fifo_txact, 0);
          tick();
          m_commit = 1'b0;
          m_idle   = 1'b1;
          #1;
          chk("pktfin_single", fifo_pktfin, 0);
          chk("post_txact", fifo_txact, 0);
          tick();
          done = 1'b1;
        end
      end
      if (restart) begin
        #1;
        chk("rewind_txact", fifo_txact, 0);
        chk("rewind_vld", tx_vld, 0);
        chk("rewind_pktfin", fifo_pktfin, 0);
        chk("rewind_len", tx_len, len);
        tick();
      end
    end
    if (blown) begin
      RST = 1'b1;
      tick();
      RST = 1'b0;
      m_idle = 1'b1;
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    RST = 1'b0;

    // Full packet from a deep FIFO, requested right after reset release
    run_packet(600, 0, -1);
    run_packet(512, 0, -1);

    // Short packet: NAK until the flush timer saturates, exact boundary
    run_packet(10, 0, -1);
    idle_until(FLUSH_CYC - 1);
    run_packet(10, 0, -1);
    run_packet(10, 0, -1);

    // Single-byte packet: tx_last on the only byte
    fifo_wrnum = 1;
    idle_until(FLUSH_CYC);
    run_packet(1, 0, -1);

    // Retry after the whole packet, retry after byte 100, ack+retry together
    run_packet(600, 1, -1);
    run_packet(700, 2, 100);
    run_packet(600, 3, -1);

    // Reset in the middle of SEND
    fifo_wrnum = 600;
    in_req = 1'b1;
    tick();
    in_req = 1'b0;
    m_idle = 1'b0;
    tick();
    tick();
    tx_pop = 1'b1;
    #1 chk("pre_rst_vld", tx_vld, 1);
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    m_idle = 1'b1;
    chk_all_zero("mid_rst");
    tx_pop = 1'b0;
    tick();
    run_packet(0, 0, -1);

    // Randomized traffic against the model
    for (int i = 0; i < 10; i++) begin
      int r, wr;
      r = $urandom_range(9, 0);
      if (r < 5)      wr = $urandom_range(1023, 512);
      else if (r < 9) wr = $urandom_range(511, 1);
      else            wr = 0;
      if (r == 8) begin
        fifo_wrnum = wr[ASIZE:0];
        idle_until(FLUSH_CYC);
      end
      run_packet(wr, $urandom_range(3, 0), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_tx_pkt_ctrl.md
USB_TX_PKT_CTRL -- requirements
Module: usb_tx_pkt_ctrl

Interface
REQ-001 SHALL have parameter MAX_PKT, default 512, meaning maximum IN packet payload in bytes.
REQ-002 SHALL have parameter FLUSH_CYC, default 4096, meaning idle cycles before a short packet is released.
REQ-003 SHALL have parameter ASIZE, default 9, meaning packet-FIFO address width; count width is ASIZE+1.
REQ-004 SHALL provide CLK  in  1  single clock; all logic on rising edge.
REQ-005 SHALL provide RST  in  1  reset; synchronous, active-high.
REQ-006 SHALL provide fifo_wrnum  in  ASIZE+1  bytes buffered beyond last committed packet.
REQ-007 SHALL provide in_req  in  1  one-cycle pulse: host IN token for this endpoint.
REQ-008 SHALL provide tx_pop  in  1  USB engine consumes the current byte.
REQ-009 SHALL provide usb_ack  in  1  one-cycle pulse: host ACKed the packet.
REQ-010 SHALL provide usb_retry  in  1  one-cycle pulse: packet lost or timed out; resend.
REQ-011 SHALL provide fifo_read  out  1  FIFO read strobe.
REQ-012 SHALL provide fifo_txact  out  1  packet-active level to FIFO; its rising edge rewinds the read pointer.
REQ-013 SHALL provide fifo_pktfin  out  1  one-cycle commit pulse to FIFO.
REQ-014 SHALL provide tx_vld / tx_last / tx_nak  out  1 each  byte valid, final byte, NAK response pulse.
REQ-015 SHALL provide tx_len  out  ASIZE+1  length of the packet in flight.

Function
REQ-016 SHALL implement states IDLE, ARM, SEND, WAIT_ACK, COMMIT, REWIND.
REQ-017 IDLE: on in_req, if wrnum >= MAX_PKT or (wrnum > 0 and flush timer expired), SHALL latch tx_len = min(wrnum, MAX_PKT) and go to ARM; otherwise SHALL pulse tx_nak for 1 cycle and stay in IDLE.
REQ-018 If wrnum = 0 at in_req, SHALL NAK regardless of the flush timer.
REQ-019 fifo_txact SHALL be 1 in ARM, SEND and WAIT_ACK, and 0 in all other states.
REQ-020 ARM SHALL last exactly 2 cycles with fifo_read = 0, covering the FIFO's 2-stage txact edge detect, then go to SEND.
REQ-021 SEND: tx_vld = 1; fifo_read = tx_pop & tx_vld; a down-counter loaded with tx_len decrements per pop.
REQ-022 tx_last SHALL be 1 while the remaining count = 1; the pop of that byte SHALL move the state to WAIT_ACK.
REQ-023 WAIT_ACK: usb_ack SHALL go to COMMIT and usb_retry SHALL go to REWIND; if both occur in the same cycle, ack SHALL win.
REQ-024 COMMIT SHALL pulse fifo_pktfin for exactly 1 cycle, clear the flush timer, and return to IDLE.
REQ-025 REWIND SHALL hold fifo_txact = 0 for 1 cycle, then go to ARM with tx_len unchanged, so the FIFO rewinds to the packet start.
REQ-026 usb_retry during SEND SHALL abort the packet: stop reads and go to REWIND.
REQ-027 usb_ack outside WAIT_ACK and in_req outside IDLE SHALL be ignored.
REQ-028 Flush timer SHALL count in IDLE while 0 < wrnum < MAX_PKT, saturate at FLUSH_CYC, and clear when wrnum = 0 or in COMMIT.
REQ-029 tx_len SHALL never exceed MAX_PKT.
REQ-030 All compares SHALL be unsigned at width ASIZE+1.

Reset
REQ-031 With RST = 1 at a clock edge, the block SHALL enter IDLE with all outputs 0, the counter 0 and the timer 0, including when reset is applied mid-packet.
REQ-032 After release, the first in_req SHALL be honoured in the next cycle.

Structure
REQ-033 Package usb_tx_pkg SHALL hold the state encoding, MAX_PKT/FLUSH_CYC defaults and count-width constants.
REQ-034 The flush timer SHALL be a sub-module, usb_tx_flush_timer (inputs: run, clr; output: expired).

Verification
REQ-035 wrnum = 600, in_req -> tx_len = 512; txact rises; after 2 cycles, 512 pops with tx_last on pop 512; usb_ack -> one pktfin pulse.
REQ-036 wrnum = 10, in_req before FLUSH_CYC -> tx_nak pulse and no txact; in_req after FLUSH_CYC idle cycles -> tx_len = 10 packet.
REQ-037 usb_retry after 512 bytes -> txact low 1 cycle, then high again; the same 512 bytes are re-sent; no pktfin until ack.
REQ-038 usb_retry after byte 100 of SEND -> reads stop, REWIND, full packet resent from byte 0.
REQ-039 usb_ack and usb_retry in the same cycle in WAIT_ACK -> COMMIT taken.
REQ-040 RST asserted mid-SEND -> next cycle IDLE, all outputs 0; wrnum = 0 with in_req -> tx_nak.
